// File: rtl/chunked_add_sequencer_if.sv
// rtl/chunked_add_sequencer_if.sv - start/done handshake bundle for chunked_add_sequencer
//
// Signals:
//   start_valid/start_ready  request handshake carrying a, b, c_in, sub
//   busy                     operation in progress
//   done_valid/done_ready    result handshake carrying sum, c_out, overflow
// Modports:
//   master  requester/consumer side
//   slave   sequencer side
interface chunked_add_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start_valid, a, b, c_in, sub, done_ready,
        input  start_ready, busy, done_valid, sum, c_out, overflow
    );

    modport slave (
        input  start_valid, a, b, c_in, sub, done_ready,
        output start_ready, busy, done_valid, sum, c_out, overflow
    );
endinterface

// File: rtl/chunked_add_sequencer.sv
// rtl/chunked_add_sequencer.sv - multi-cycle add/sub using one shared CHUNK-bit adder slice
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     chunked_add_sequencer_if.slave (start/done handshakes, operands, result)
// Operation: IDLE accepts operands, RUN adds one chunk per cycle from LSB to MSB
// with a carry register between chunks, DONE holds the result until consumed.
module chunked_add_sequencer #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    chunked_add_sequencer_if.slave  bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    logic [BW-1:0]    base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;

    always_comb begin
        base      = BW'(idx) * BW'(CHUNK);
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_q[base +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        // Carry into the top bit of the slice: the top sum bit is a^b^cin, so
        // cin falls out of the ripple chain without a second adder.
        msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        a_q   <= bus.a;
                        // Subtraction is a + ~b + 1: invert b and seed the carry.
                        b_q   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub ? 1'b1 : bus.c_in;
                        idx   <= '0;
                        sum_q <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry                <= chunk_sum[CHUNK];
                    if (idx == IDX_W'(N - 1)) begin
                        c_out_q <= chunk_sum[CHUNK];
                        ovf_q   <= msb_cin ^ chunk_sum[CHUNK];
                        idx     <= '0;
                        state   <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.done_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == S_IDLE);
    assign bus.busy        = (state == S_RUN);
    assign bus.done_valid  = (state == S_DONE);
    assign bus.sum         = sum_q;
    assign bus.c_out       = c_out_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// tb/tb_chunked_add_sequencer.sv - self-checking bench for chunked_add_sequencer
module tb_chunked_add_sequencer;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    chunked_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

    chunked_add_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Reference: whole-word arithmetic, returns {overflow, c_out, sum}.
    function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] bv;
        logic             ci;
        logic [WIDTH:0]   full;
        logic             ovf;
        bv   = sub ? ~b : b;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bv} + {{WIDTH{1'b0}}, ci};
        ovf  = (a[WIDTH-1] == bv[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ovf, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    // Present one request from IDLE and wait (bounded) for done_valid.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, output int lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sub; bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        lat = 0;
        while (bus.done_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.done_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        @(negedge clk);
        checks++;
        if ({bus.start_ready, bus.busy, bus.done_valid, bus.c_out, bus.overflow, bus.sum} !== {5'b10000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: got sr/busy/dv/co/ov/sum=%b%b%b%b%b/%h expected 10000/0000",
                     bus.start_ready, bus.busy, bus.done_valid, bus.c_out, bus.overflow, bus.sum);
        end
        resetn = 1'b1;
    endtask

    task automatic test_arith_vectors();
        logic [WIDTH-1:0] ta [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
        logic [WIDTH-1:0] tb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        logic             tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic             ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH+1:0] te [5] = '{{2'b00, 16'h0100}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                                     {2'b00, 16'hFFFF}, {2'b11, 16'h7FFF}};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], tc[i], ts[i], lat);
            checks++;
            if (lat !== N) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d cycles expected %0d", i, lat, N);
            end
            checks++;
            if ({bus.overflow, bus.c_out, bus.sum} !== te[i]) begin
                errors++;
                $display("FAIL vec%0d_result: got ovf/cout/sum=%b/%b/%h expected %b/%b/%h", i,
                         bus.overflow, bus.c_out, bus.sum, te[i][WIDTH+1], te[i][WIDTH], te[i][WIDTH-1:0]);
            end
            consume();
            checks++;
            if ({bus.start_ready, bus.done_valid} !== 2'b10) begin
                errors++;
                $display("FAIL vec%0d_release: got sr/dv=%b%b expected 10", i, bus.start_ready, bus.done_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [WIDTH+1:0] exp;
        exp = ref_model(16'h1234, 16'h1111, 1'b1, 1'b0);
        do_op(16'h1234, 16'h1111, 1'b1, 1'b0, lat);
        checks++;
        if ({bus.overflow, bus.c_out, bus.sum} !== {2'b00, 16'h2346}) begin
            errors++;
            $display("FAIL bp_result: got sum=%h expected 2346", bus.sum);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.c_in = 1'b1; bus.sub = 1'b0; bus.start_valid = 1'b1;
            end else begin
                bus.start_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if ({bus.done_valid, bus.start_ready, bus.busy, bus.overflow, bus.c_out, bus.sum} !== {3'b100, exp}) begin
                errors++;
                $display("FAIL bp_hold%0d: got dv/sr/busy=%b%b%b sum=%h expected 100 sum=%h",
                         i, bus.done_valid, bus.start_ready, bus.busy, bus.sum, exp[WIDTH-1:0]);
            end
        end
        bus.start_valid = 1'b0;
        consume();
        checks++;
        if ({bus.start_ready, bus.done_valid, bus.sum} !== {2'b10, exp[WIDTH-1:0]}) begin
            errors++;
            $display("FAIL bp_idle_keep: got sr/dv=%b%b sum=%h expected 10 sum=%h",
                     bus.start_ready, bus.done_valid, bus.sum, exp[WIDTH-1:0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.c_in = 1'b0; bus.sub = 1'b0; bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.sum === 16'h0000) begin
            errors++;
            $display("FAIL mid_run_progress: got busy=%b sum=%h expected busy=1 nonzero partial sum", bus.busy, bus.sum);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.start_ready, bus.busy, bus.done_valid, bus.c_out, bus.overflow, bus.sum} !== {5'b10000, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset: got sr/busy/dv/co/ov/sum=%b%b%b%b%b/%h expected 10000/0000",
                     bus.start_ready, bus.busy, bus.done_valid, bus.c_out, bus.overflow, bus.sum);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_valid === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL discarded_op: got %0d active cycles after reset expected 0", seen);
        end
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.overflow, bus.c_out, bus.sum} !== {2'b00, 16'h5555} || lat !== N) begin
            errors++;
            $display("FAIL post_reset_op: got sum=%h lat=%0d expected 5555 lat=%0d", bus.sum, lat, N);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b;
        logic             cin, sub;
        logic [WIDTH+1:0] exp;
        int               cyc;
        @(negedge clk);
        bus.done_ready = 1'b1;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sub; bus.start_valid = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            exp = ref_model(a, b, cin, sub);
            @(posedge clk);
            #1;
            cyc = 1;
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
            bus.c_in = 1'($urandom); bus.sub = 1'($urandom);
            while (bus.done_valid !== 1'b1 && cyc < 30) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            checks++;
            if ({bus.overflow, bus.c_out, bus.sum} !== exp || cyc !== N + 1) begin
                errors++;
                $display("FAIL b2b_result%0d: a=%h b=%h cin=%b sub=%b got ovf/cout/sum=%b/%b/%h at %0d expected %b/%b/%h at %0d",
                         v, a, b, cin, sub, bus.overflow, bus.c_out, bus.sum, cyc,
                         exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0], N + 1);
            end
            @(posedge clk);
            #1;
            cyc++;
            checks++;
            if (bus.start_ready !== 1'b1 || cyc !== N + 2) begin
                errors++;
                $display("FAIL b2b_period%0d: got start_ready=%b period=%0d expected 1 period=%0d",
                         v, bus.start_ready, cyc, N + 2);
            end
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sub;
            if (v == 999) bus.start_valid = 1'b0;
        end
        bus.done_ready = 1'b0;
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.c_in        = 1'b0;
        bus.sub         = 1'b0;
        test_reset();
        test_arith_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
